erasable_ram_ctrl: RTL and testbench
====================================

Name: erasable_ram_ctrl

Overview:
- Synchronous sequencer and arbiter in front of the 2K x 16 asynchronous erasable RAM (active-low E_/G_/W_/UB_/LB_, shared bidirectional DQ).
- Shares the RAM between two requesters: port 0, the AGC core erasable path, and port 1, the monitor/debug port.
- Generates strobe timing that guarantees G_ and W_ are never low together.
- Registers read data and returns one-cycle ack pulses.

Parameters:
- RD_WAIT, 2, clocks G_ held low before read data is sampled (min 1)
- WR_WAIT, 2, clocks W_ held low (min 1)
- ADDR_W, 11, RAM word address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req0  in  1  core request; hold until ack0
- we0  in  1  core write (1) / read (0)
- addr0  in  ADDR_W  core address
- wdata0  in  16  core write data
- ack0  out  1  one-cycle completion pulse
- req1, we1, addr1, wdata1, ack1  same as port 0, monitor side
- rdata  out  16  read data; valid in the ack cycle, held until next read completes
- ram_e_n, ram_g_n, ram_w_n, ram_ub_n, ram_lb_n  out  1 each  RAM strobes
- ram_addr  out  ADDR_W  RAM address
- ram_dq_out  out  16  write data toward DQ
- ram_dq_oe  out  1  enables the board-level DQ driver
- ram_dq_in  in  16  DQ sampled value
- busy  out  1  FSM not in IDLE
- parity_err  out  1  see Optional Feature; tied 0 when the feature is absent

Behaviour:
- Reset state (asynchronous):
  - All RAM strobes are 1.
  - ram_dq_oe is 0; ram_addr, ram_dq_out and rdata are 0.
  - ack0, ack1 and busy are 0.
  - FSM is in IDLE; last_grant is 1, so port 0 wins the first tie.
- All outputs are registered.
- FSM states:
  - IDLE
    - Arbitrate among pending requests.
    - Single requester: grant it.
    - Both requesting: round-robin; the port not granted last wins.
    - Latch port, we, addr and wdata.
    - Go to SETUP.
  - SETUP (1 clk)
    - ram_addr is valid; ram_e_n=0, ram_ub_n=0, ram_lb_n=0.
    - Write: ram_dq_oe=1 and ram_dq_out driven.
    - Read → RD; write → WR.
  - RD (RD_WAIT clks)
    - ram_g_n=0.
    - In the last RD cycle, ram_dq_in is sampled into rdata.
    - Go to DONE.
  - WR (WR_WAIT clks)
    - ram_w_n=0 with ram_g_n=1.
    - Go to WHOLD.
  - WHOLD (1 clk)
    - ram_w_n=1; data and address are held; ram_dq_oe stays 1.
    - Go to DONE.
  - DONE (1 clk)
    - All strobes are 1 and ram_dq_oe=0.
    - ack of the granted port pulses.
    - last_grant updates.
    - Go to IDLE.
- Latency:
  - Read: 3+RD_WAIT clks from the request sampled in IDLE to ack (5 at default).
  - Write: 4+WR_WAIT clks (6 at default).
- Requesters must deassert req in the ack cycle or on the next clock.
  - A req still high in the IDLE cycle after ack is treated as a new request.
- Request inputs are ignored outside IDLE; latched addr and data are immune to input changes.
- Invariant: ram_g_n and ram_w_n are never both 0. Read and write strobes are never overlapped or merged.
- ram_e_n is high for at least 1 clk (DONE) between consecutive accesses.
- Reset mid-access aborts immediately:
  - Strobes go to 1 and ram_dq_oe to 0.
  - No ack is issued; the RAM contents for that access are undefined.

Optional Feature:
- Macro: ERASABLE_RAM_PARITY_EN.
- Defined:
  - On write, bit 0 of ram_dq_out is replaced with odd parity over wdata[15:1].
  - On read, odd parity over all 16 bits of ram_dq_in is checked.
  - On a mismatch, parity_err pulses together with ack; rdata still returns the raw word.
- Undefined:
  - Data passes through unmodified.
  - parity_err is constant 0.

Decomposition:
- Package erasable_ram_pkg holds:
  - state enum (IDLE, SETUP, RD, WR, WHOLD, DONE)
  - RD_WAIT_DEF and WR_WAIT_DEF
  - ADDR_W_DEF
  - odd-parity function
- One sub-module: erasable_ram_arb, the two-port round-robin arbiter with last_grant register. It outputs grant index and grant valid.

Test Plan:
- Port 0 write addr 11'o0123 data 16'o12345, then read the same address:
  - Write ack0 at clk 6.
  - Read ack0 at clk 5 with rdata=16'o12345.
  - ram_w_n is low only while ram_g_n=1.
- Read of an unwritten address 11'o0007 after model init → rdata=16'o40000.
- req0 and req1 asserted in the same cycle, both reads, from reset:
  - Port 0 is served first, then port 1.
  - Repeated simultaneous requests alternate grants 0,1,0,1.
- Back-to-back port 1 writes:
  - ram_e_n is high for ≥1 clk between them.
  - A $finish check (G_ and W_ both low) never fires.
- rst asserted during the WR state:
  - Strobes go high and ram_dq_oe goes 0 asynchronously; no ack.
  - The next request completes normally.
- ERASABLE_RAM_PARITY_EN defined:
  - Write 16'o00002 → ram_dq_out 16'o00003.
  - Forced read of 16'o00002 → parity_err=1 in the ack cycle.

Source files
------------

// File: rtl/erasable_ram_pkg.sv
// Shared definitions for the erasable RAM sequencer/arbiter slice.
// State codes are plain localparam constants so that older tools and netlist
// dumps keep reading the state register as a simple 3-bit value.
// Optional build macro used by this slice: ERASABLE_RAM_PARITY_EN.
package erasable_ram_pkg;

  localparam int RD_WAIT_DEF = 2;
  localparam int WR_WAIT_DEF = 2;
  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W      = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_RD    = 3'd2;
  localparam state_t ST_WR    = 3'd3;
  localparam state_t ST_WHOLD = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // XOR reduction: 1 when the word holds an odd number of ones.
  // A stored word carries bit 0 chosen so the full 16-bit word reduces to 0.
  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/erasable_ram_arb.sv
// Two-port round-robin arbiter for the erasable RAM.
// When both ports request together, the port that was not served last wins.
// last_grant resets to 1 so port 0 wins the first tie after reset.
module erasable_ram_arb
  import erasable_ram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic arb_en,
  input  logic update,
  input  logic upd_port,
  output logic grant_idx,
  output logic grant_valid
);

  logic last_grant;

  // Pick a winner among the pending ports; only meaningful while arb_en is high.
  always_comb begin
    grant_valid = arb_en & (req0 | req1);
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

  // Remember which port finished last so the next tie goes to the other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= upd_port;
    end
  end

endmodule

// File: rtl/erasable_ram_ctrl.sv
// Sequencer and arbiter in front of the 2K x 16 asynchronous erasable RAM.
// Port 0 is the core erasable path, port 1 the monitor/debug port.
// Every output is a register; strobe values are computed from the state being
// entered so they line up with the state register. G_ and W_ are only ever
// pulled low in separate states, so they can never be low together.
// Optional build macro: ERASABLE_RAM_PARITY_EN (write-side parity insertion
// into bit 0 and read-side parity checking reported on parity_err).
module erasable_ram_ctrl
  import erasable_ram_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [15:0]       wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata1,
  output logic              ack1,
  output logic [15:0]       rdata,
  output logic              ram_e_n,
  output logic              ram_g_n,
  output logic              ram_w_n,
  output logic              ram_ub_n,
  output logic              ram_lb_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_dq_out,
  output logic              ram_dq_oe,
  input  logic [15:0]       ram_dq_in,
  output logic              busy,
  output logic              parity_err
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              port_q;
  logic              we_q;

  logic              grant_idx;
  logic              grant_valid;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [15:0]       wdata_sel;
  logic [15:0]       wr_word;
  logic              rd_last;

  erasable_ram_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .arb_en      (state == ST_IDLE),
    .update      (state == ST_DONE),
    .upd_port    (port_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Route the winning port's command fields toward the latch point.
  always_comb begin
    we_sel    = grant_idx ? we1    : we0;
    addr_sel  = grant_idx ? addr1  : addr0;
    wdata_sel = grant_idx ? wdata1 : wdata0;
  end

  assign rd_last = (state == ST_RD) && (cnt == '0);

`ifdef ERASABLE_RAM_PARITY_EN
  // Replace bit 0 of the outgoing word with the parity of bits 15..1.
  always_comb begin
    wr_word = {wdata_sel[15:1], odd_parity({1'b0, wdata_sel[15:1]})};
  end

  // Flag a bad word in the same cycle the read ack goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= rd_last ? odd_parity(ram_dq_in) : 1'b0;
    end
  end
`else
  // Data passes straight through and no parity is ever reported.
  always_comb begin
    wr_word = wdata_sel;
  end

  assign parity_err = 1'b0;
`endif

  // Main access sequencer: IDLE -> SETUP -> RD/WR(+WHOLD) -> DONE -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      ram_e_n    <= 1'b1;
      ram_g_n    <= 1'b1;
      ram_w_n    <= 1'b1;
      ram_ub_n   <= 1'b1;
      ram_lb_n   <= 1'b1;
      ram_dq_oe  <= 1'b0;
      ram_addr   <= '0;
      ram_dq_out <= '0;
      rdata      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            port_q   <= grant_idx;
            we_q     <= we_sel;
            ram_addr <= addr_sel;
            ram_e_n  <= 1'b0;
            ram_ub_n <= 1'b0;
            ram_lb_n <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_SETUP;
            if (we_sel) begin
              ram_dq_oe  <= 1'b1;
              ram_dq_out <= wr_word;
            end
          end
        end
        ST_SETUP: begin
          if (we_q) begin
            ram_w_n <= 1'b0;
            cnt     <= CNT_W'(WR_WAIT - 1);
            state   <= ST_WR;
          end else begin
            ram_g_n <= 1'b0;
            cnt     <= CNT_W'(RD_WAIT - 1);
            state   <= ST_RD;
          end
        end
        ST_RD: begin
          if (cnt == '0) begin
            rdata    <= ram_dq_in;
            ram_g_n  <= 1'b1;
            ram_e_n  <= 1'b1;
            ram_ub_n <= 1'b1;
            ram_lb_n <= 1'b1;
            ack0     <= ~port_q;
            ack1     <= port_q;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR: begin
          if (cnt == '0) begin
            ram_w_n <= 1'b1;
            state   <= ST_WHOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WHOLD: begin
          ram_e_n   <= 1'b1;
          ram_ub_n  <= 1'b1;
          ram_lb_n  <= 1'b1;
          ram_dq_oe <= 1'b0;
          ack0      <= ~port_q;
          ack1      <= port_q;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ram_e_n   <= 1'b1;
          ram_g_n   <= 1'b1;
          ram_w_n   <= 1'b1;
          ram_ub_n  <= 1'b1;
          ram_lb_n  <= 1'b1;
          ram_dq_oe <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_erasable_ram_ctrl.sv
// Self-checking bench for erasable_ram_ctrl.
// A behavioural RAM answers the strobes; a reference memory (associative
// array) predicts read data from the write history. Covers a vector table,
// random traffic, tie arbitration, reset abort and the parity path
// (expectations follow ERASABLE_RAM_PARITY_EN when it is defined).
module tb_erasable_ram_ctrl;
  import erasable_ram_pkg::*;

  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;
  localparam int ADDR_W  = 11;
`ifdef ERASABLE_RAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [15:0] INIT_WORD = 16'o40000;

  logic              clk, rst;
  logic              req0, we0, ack0, req1, we1, ack1;
  logic [ADDR_W-1:0] addr0, addr1, ram_addr;
  logic [15:0]       wdata0, wdata1, rdata, ram_dq_out, ram_dq_in;
  logic              ram_e_n, ram_g_n, ram_w_n, ram_ub_n, ram_lb_n;
  logic              ram_dq_oe, busy, parity_err;

  erasable_ram_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata),
    .ram_e_n(ram_e_n), .ram_g_n(ram_g_n), .ram_w_n(ram_w_n),
    .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n),
    .ram_addr(ram_addr), .ram_dq_out(ram_dq_out), .ram_dq_oe(ram_dq_oe),
    .ram_dq_in(ram_dq_in), .busy(busy), .parity_err(parity_err)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous RAM, with an override for forced read values.
  logic [15:0] ram_mem [0:2047];
  logic        force_en;
  logic [15:0] force_val;

  always_comb begin
    if (force_en) ram_dq_in = force_val;
    else if (!ram_e_n && !ram_g_n) ram_dq_in = ram_mem[ram_addr];
    else ram_dq_in = 16'h0000;
  end

  // Commit write data while W_ is low and the DQ driver is on.
  always @(negedge clk) begin
    if (!ram_e_n && !ram_w_n && ram_dq_oe) begin
      if (!ram_ub_n) ram_mem[ram_addr][15:8] <= ram_dq_out[15:8];
      if (!ram_lb_n) ram_mem[ram_addr][7:0]  <= ram_dq_out[7:0];
    end
  end

  // Bus monitors: strobe overlap, write-word capture, ack pulse counts.
  int          overlap_cnt = 0;
  int          ack0_cnt = 0;
  int          ack1_cnt = 0;
  logic [15:0] last_wr_word = 16'h0;

  always @(negedge clk) begin
    if (!ram_g_n && !ram_w_n) overlap_cnt++;
    if (!ram_w_n) last_wr_word = ram_dq_out;
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
  end

  // Reference model state.
  logic [15:0] ref_mem [int];
  int exp_ack0 = 0;
  int exp_ack1 = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          ok;
    int          lat;
    logic [15:0] rdata;
    logic        perr;
    logic        strobes_idle;
    logic        other_ack;
  } result_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          raw;
    int          exp_lat;
  } vec_t;

  function automatic logic [15:0] stored_word(input logic [15:0] d);
    if (PAR_EN) return {d[15:1], ^d[15:1]};
    return d;
  endfunction

  function automatic logic [15:0] ref_read(input logic [10:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return INIT_WORD;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  // Raise one request in an IDLE cycle, hold it until ack, then drop it.
  task automatic applyStimulus(input bit port, input bit we, input logic [10:0] addr,
                               input logic [15:0] wdata, output result_t r);
    r = '{ok: 1'b0, lat: 0, rdata: 16'h0, perr: 1'b0, strobes_idle: 1'b0, other_ack: 1'b0};
    @(negedge clk);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (port) begin we1 = ~we; addr1 = 11'($urandom); wdata1 = 16'($urandom); end
        else      begin we0 = ~we; addr0 = 11'($urandom); wdata0 = 16'($urandom); end
      end
      if (port ? ack1 : ack0) begin
        r.ok           = 1'b1;
        r.lat          = n + 1;
        r.rdata        = rdata;
        r.perr         = parity_err;
        r.strobes_idle = ({ram_e_n, ram_g_n, ram_w_n, ram_ub_n, ram_lb_n, ram_dq_oe} == 6'b111110);
        r.other_ack    = port ? ack0 : ack1;
        break;
      end
    end
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // One access checked against the reference memory and latency rules.
  task automatic doAccess(input bit port, input bit we, input logic [10:0] addr,
                          input logic [15:0] wdata, input string tag, output result_t r);
    logic [15:0] exp;
    applyStimulus(port, we, addr, wdata, r);
    checkOutput({tag, "_ack"}, 32'(r.ok), 32'd1);
    if (r.ok) begin
      if (port) exp_ack1++; else exp_ack0++;
      checkOutput({tag, "_latency"}, 32'(r.lat), we ? 32'(4 + WR_WAIT) : 32'(3 + RD_WAIT));
      checkOutput({tag, "_strobes_in_ack"}, 32'(r.strobes_idle), 32'd1);
      checkOutput({tag, "_other_ack"}, 32'(r.other_ack), 32'd0);
      if (we) begin
        checkOutput({tag, "_dq_out"}, 32'(last_wr_word), 32'(stored_word(wdata)));
        ref_mem[int'(addr)] = stored_word(wdata);
      end else begin
        exp = ref_read(addr);
        checkOutput({tag, "_rdata"}, 32'(r.rdata), 32'(exp));
        checkOutput({tag, "_parity_err"}, 32'(r.perr), 32'(PAR_EN & (^exp)));
      end
    end
  endtask

  vec_t    vecs[9];
  result_t res;
  int      order[$];
  int      exp_order[4] = '{0, 1, 0, 1};
  int      a0_before;
  bit      saw_w;

  // Top-level test sequence.
  initial begin
    vecs[0] = '{0, 1, 11'o0123, 16'o12345,  16'o0,      0, 6};
    vecs[1] = '{0, 0, 11'o0123, 16'o0,      16'o12345,  0, 5};
    vecs[2] = '{0, 0, 11'o0007, 16'o0,      16'o40000,  1, 5};
    vecs[3] = '{1, 1, 11'o0200, 16'o177777, 16'o0,      0, 6};
    vecs[4] = '{1, 0, 11'o0200, 16'o0,      16'o177777, 0, 5};
    vecs[5] = '{0, 1, 11'o3777, 16'o055555, 16'o0,      0, 6};
    vecs[6] = '{1, 0, 11'o3777, 16'o0,      16'o055555, 0, 5};
    vecs[7] = '{1, 1, 11'o0000, 16'o0,      16'o0,      0, 6};
    vecs[8] = '{0, 0, 11'o0000, 16'o0,      16'o0,      0, 5};

    for (int i = 0; i < 2048; i++) ram_mem[i] = INIT_WORD;
    rst = 1'b1; force_en = 1'b0; force_val = 16'h0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    #12;
    checkOutput("reset_strobes", 32'({ram_e_n, ram_g_n, ram_w_n, ram_ub_n, ram_lb_n}), 32'b11111);
    checkOutput("reset_oe_busy_ack", 32'({ram_dq_oe, busy, ack0, ack1, parity_err}), 32'd0);
    checkOutput("reset_addr", 32'(ram_addr), 32'd0);
    checkOutput("reset_dq_out", 32'(ram_dq_out), 32'd0);
    checkOutput("reset_rdata", 32'(rdata), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      doAccess(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i), res);
      checkOutput($sformatf("vec%0d_tbl_latency", i), 32'(res.lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].we)
        checkOutput($sformatf("vec%0d_tbl_rdata", i), 32'(res.rdata),
                    32'(vecs[i].raw ? vecs[i].exp_rdata : stored_word(vecs[i].exp_rdata)));
    end

    // Back-to-back port 1 writes, then read both back.
    doAccess(1, 1, 11'o0400, 16'o11111, "b2b_w0", res);
    doAccess(1, 1, 11'o0401, 16'o22222, "b2b_w1", res);
    doAccess(1, 0, 11'o0400, 16'o0, "b2b_r0", res);
    doAccess(0, 0, 11'o0401, 16'o0, "b2b_r1", res);

    // Simultaneous reads from reset: two tie rounds must serve 0,1,0,1.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int round = 0; round < 2; round++) begin
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 11'o0123;
      req1 = 1'b1; we1 = 1'b0; addr1 = 11'o0200;
      for (int n = 0; n < 40 && (req0 || req1); n++) begin
        @(negedge clk);
        if (ack0 && req0) begin
          order.push_back(0); exp_ack0++; req0 = 1'b0;
          checkOutput("tie_rdata0", 32'(rdata), 32'(ref_read(11'o0123)));
        end
        if (ack1 && req1) begin
          order.push_back(1); exp_ack1++; req1 = 1'b0;
          checkOutput("tie_rdata1", 32'(rdata), 32'(ref_read(11'o0200)));
        end
      end
      req0 = 1'b0; req1 = 1'b0;
    end
    checkOutput("tie_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      checkOutput($sformatf("tie_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // Reset asserted while W_ is low aborts the access without an ack.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'o1777; wdata0 = 16'o07070;
    saw_w = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!ram_w_n) begin saw_w = 1'b1; break; end
    end
    checkOutput("abort_reached_wr", 32'(saw_w), 32'd1);
    req0 = 1'b0;
    a0_before = ack0_cnt;
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_strobes", 32'({ram_e_n, ram_g_n, ram_w_n, ram_ub_n, ram_lb_n}), 32'b11111);
    checkOutput("abort_oe_busy", 32'({ram_dq_oe, busy}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_ack", 32'(ack0_cnt), 32'(a0_before));
    doAccess(0, 0, 11'o0123, 16'o0, "after_abort", res);

    // Parity path: bit 0 insertion on write, forced bad word on read.
    doAccess(0, 1, 11'o0300, 16'o00002, "par_w", res);
    checkOutput("par_dq_out", 32'(last_wr_word), PAR_EN ? 32'o00003 : 32'o00002);
    force_en = 1'b1; force_val = 16'o00002;
    applyStimulus(1, 0, 11'o0300, 16'o0, res);
    force_en = 1'b0;
    checkOutput("par_forced_ack", 32'(res.ok), 32'd1);
    if (res.ok) exp_ack1++;
    checkOutput("par_forced_rdata", 32'(res.rdata), 32'o00002);
    checkOutput("par_forced_err", 32'(res.perr), 32'(PAR_EN));

    // Randomised traffic checked against the reference memory.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      doAccess(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               11'($urandom_range(0, 31)), 16'($urandom), $sformatf("rnd%0d", i), res);
    end

    repeat (3) @(negedge clk);
    checkOutput("no_g_w_overlap", 32'(overlap_cnt), 32'd0);
    checkOutput("ack0_pulse_total", 32'(ack0_cnt), 32'(exp_ack0));
    checkOutput("ack1_pulse_total", 32'(ack1_cnt), 32'(exp_ack1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
